// File: rtl/otter_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// otter_fetch_unit_if
//
// Bundles the two handshakes of the OTTER fetch front end:
//   - instruction memory port: imem_req/imem_gnt request-grant with
//     imem_addr, and imem_rvalid/imem_rdata in-order responses;
//   - decode port: ir_valid/ir_ready with the instruction ir and its
//     address ir_pc.
//
// Handshake rules (the only place they are written down):
//   - A request transfers in a cycle where imem_req=1 and imem_gnt=1.
//     While imem_req=1 and imem_gnt=0 the fetch unit holds imem_addr.
//   - imem_rvalid is a one-cycle strobe per granted request. Responses
//     come back in grant order, at least one cycle after the grant.
//   - An instruction transfers in a cycle where ir_valid=1 and ir_ready=1.
//     While ir_valid=1 and ir_ready=0, ir and ir_pc are held stable.
//
// Modports:
//   master - the fetch unit (drives imem_req/imem_addr, ir_valid/ir/ir_pc)
//   slave  - the environment (memory and decode)
// -----------------------------------------------------------------------------
interface otter_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir;
   logic [31:0] ir_pc;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata,
      output ir_valid,
      input  ir_ready,
      output ir,
      output ir_pc
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata,
      input  ir_valid,
      output ir_ready,
      input  ir,
      input  ir_pc
   );
endinterface

// File: rtl/otter_fetch_unit.sv
// -----------------------------------------------------------------------------
// otter_fetch_unit
//
// Instruction fetch front end for the OTTER MCU. Owns the program counter,
// issues word fetches over the imem request/grant + response-valid port,
// buffers returned words together with their address and presents them to
// decode. On a redirect the fetch PC is replaced by the selected target and
// every wrong-path fetch (buffered or still in flight) is discarded.
//
// Parameters:
//   RESET_VEC - PC loaded on reset
//   DEPTH     - outstanding requests plus buffered instructions (1..4)
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   bus           if   master side of otter_fetch_unit_if (imem + decode)
//   redirect      in   single-cycle redirect pulse
//   pc_source     in   target select: 1=jalr 2=branch 3=jal 4=mtvec 5=mepc;
//                      other codes make redirect a no-op
//   jalr, branch, jal, mtvec, mepc
//                 in   candidate redirect targets
//   pc            out  next address to be fetched (same as bus.imem_addr)
//   addr_misalign out  one-cycle pulse after a redirect to a target whose
//                      low two bits are non-zero
// -----------------------------------------------------------------------------
module otter_fetch_unit #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          DEPTH     = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   otter_fetch_unit_if.master bus,
   input  logic               redirect,
   input  logic [2:0]         pc_source,
   input  logic [31:0]        jalr,
   input  logic [31:0]        branch,
   input  logic [31:0]        jal,
   input  logic [31:0]        mtvec,
   input  logic [31:0]        mepc,
   output logic [31:0]        pc,
   output logic               addr_misalign
);

   // Counter width holds 0..DEPTH; pointer width indexes DEPTH entries.
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [31:0]   pc_q;
   logic          run_q;        // low for the cycle right after reset
   logic [CW-1:0] out_q;        // granted requests not yet answered
   logic [CW-1:0] drop_q;       // how many of out_q are wrong-path
   logic [CW-1:0] fifo_cnt_q;

   // Address tags of in-flight requests, popped as responses return.
   logic [31:0]   tag_mem [DEPTH];
   logic [PW-1:0] tag_wr_q;
   logic [PW-1:0] tag_rd_q;

   // Instruction buffer of {ir_pc, ir}.
   logic [31:0]   fifo_pc [DEPTH];
   logic [31:0]   fifo_ir [DEPTH];
   logic [PW-1:0] fifo_wr_q;
   logic [PW-1:0] fifo_rd_q;

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   logic [31:0]   target;
   logic          redirect_ok;
   logic          ir_valid;
   logic          pop;
   logic          req;
   logic          grant;
   logic          resp;
   logic          push;
   logic [CW:0]   credit_used;
   logic [CW-1:0] out_next;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Target select. Unused codes leave redirect_ok low so the pulse has no
   // effect at all (PC, buffers and request flow untouched).
   always_comb begin
      target      = pc_q;
      redirect_ok = 1'b0;
      case (pc_source)
         3'd1: begin target = jalr;   redirect_ok = redirect; end
         3'd2: begin target = branch; redirect_ok = redirect; end
         3'd3: begin target = jal;    redirect_ok = redirect; end
         3'd4: begin target = mtvec;  redirect_ok = redirect; end
         3'd5: begin target = mepc;   redirect_ok = redirect; end
         default: begin end
      endcase
   end

   assign ir_valid = (fifo_cnt_q != '0);
   assign pop      = ir_valid & bus.ir_ready;

   // Credit: a slot freed by this cycle's pop is reusable right away, since
   // the earliest the new request can answer is next cycle. This is what
   // lets DEPTH=2 sustain one instruction per cycle.
   assign credit_used = {1'b0, out_q} + {1'b0, fifo_cnt_q} - {{CW{1'b0}}, pop};

   // No request in a redirect cycle: the current PC is wrong-path.
   assign req   = run_q & rst_n & ~redirect_ok & (credit_used < DEPTH_L);
   assign grant = req & bus.imem_gnt;
   assign resp  = rst_n & bus.imem_rvalid;

   // Responses while drop_q>0 are wrong-path; a response landing in the
   // redirect cycle itself is wrong-path too.
   assign push  = resp & (drop_q == '0) & ~redirect_ok;

   always_comb begin
      out_next = out_q;
      if (grant && !resp) begin
         out_next = out_q + CW'(1);
      end else if (!grant && resp) begin
         out_next = out_q - CW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_VEC & ~32'h3;
         run_q         <= 1'b0;
         out_q         <= '0;
         drop_q        <= '0;
         fifo_cnt_q    <= '0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         addr_misalign <= 1'b0;
      end else begin
         run_q         <= 1'b1;
         out_q         <= out_next;
         addr_misalign <= 1'b0;

         if (grant) begin
            pc_q     <= pc_q + 32'd4;   // wraps naturally at 2^32
            tag_wr_q <= ptr_inc(tag_wr_q);
         end
         // Tags keep popping through a redirect so they stay aligned with
         // the responses still in flight.
         if (resp) begin
            tag_rd_q <= ptr_inc(tag_rd_q);
         end

         if (redirect_ok) begin
            // grant is 0 here, so out_next already reflects this cycle's
            // response and every remaining outstanding word is wrong-path.
            pc_q          <= {target[31:2], 2'b00};
            addr_misalign <= |target[1:0];
            drop_q        <= out_next;
            fifo_cnt_q    <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
         end else begin
            if (resp && (drop_q != '0)) begin
               drop_q <= drop_q - CW'(1);
            end
            if (push) begin
               fifo_wr_q <= ptr_inc(fifo_wr_q);
            end
            if (pop) begin
               fifo_rd_q <= ptr_inc(fifo_rd_q);
            end
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Storage (no reset needed: occupancy is tracked by the counters)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (grant) begin
         tag_mem[tag_wr_q] <= pc_q;
      end
      if (push) begin
         fifo_pc[fifo_wr_q] <= tag_mem[tag_rd_q];
         fifo_ir[fifo_wr_q] <= bus.imem_rdata;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.imem_req  = req;
   assign bus.imem_addr = pc_q;
   assign pc            = pc_q;

   // Zero when empty so no stale word is ever visible after reset/flush.
   assign bus.ir_valid  = ir_valid;
   assign bus.ir        = ir_valid ? fifo_ir[fifo_rd_q] : 32'h0;
   assign bus.ir_pc     = ir_valid ? fifo_pc[fifo_rd_q] : 32'h0;

endmodule

// File: tb/tb_otter_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_otter_fetch_unit
//
// Directed bench for otter_fetch_unit (RESET_VEC=0, DEPTH=2). Stimulus
// pushes the hand-derived {ir_pc, ir} stream into exp_q; a monitor pops and
// compares on every ir_valid & ir_ready. A small in-order memory model with
// programmable latency answers the fetch requests.
// -----------------------------------------------------------------------------
module tb_otter_fetch_unit;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        redirect;
   logic [2:0]  pc_source;
   logic [31:0] jalr, branch, jal, mtvec, mepc;
   logic [31:0] pc;
   logic        addr_misalign;

   otter_fetch_unit_if bus ();

   otter_fetch_unit #(
      .RESET_VEC (32'h0000_0000),
      .DEPTH     (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .redirect      (redirect),
      .pc_source     (pc_source),
      .jalr          (jalr),
      .branch        (branch),
      .jal           (jal),
      .mtvec         (mtvec),
      .mepc          (mepc),
      .pc            (pc),
      .addr_misalign (addr_misalign)
   );

   // ---------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_e;

   // Instruction memory image.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   // ---------------------------------------------------------------------
   // Memory model: in-order, responds mem_lat cycles after the grant cycle
   // ---------------------------------------------------------------------
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          mem_lat = 1;
   int          mcyc    = 0;
   logic        mm_g, mm_r, mm_rs;
   logic [31:0] mm_a;

   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         mm_g  = bus.imem_req & bus.imem_gnt;
         mm_r  = bus.imem_rvalid;
         mm_rs = rst_n;
         mm_a  = bus.imem_addr;
         @(posedge clk);
         #1;
         if (!mm_rs) begin
            pend_addr.delete();
            pend_due.delete();
         end else begin
            if (mm_r && pend_addr.size() != 0) begin
               void'(pend_addr.pop_front());
               void'(pend_due.pop_front());
            end
            if (mm_g) begin
               pend_addr.push_back(mm_a);
               pend_due.push_back(mcyc + mem_lat);
            end
         end
         mcyc++;
         if (pend_addr.size() != 0 && pend_due[0] <= mcyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr[0]);
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Monitor: compares every instruction handed to decode
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst_n && bus.ir_valid && bus.ir_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ir_unexpected: got pc=%h ir=%h, required no instruction",
                     bus.ir_pc, bus.ir);
         end else begin
            exp_e = exp_q.pop_front();
            if ({bus.ir_pc, bus.ir} !== exp_e) begin
               errors++;
               $display("FAIL ir_stream: got pc=%h ir=%h, required pc=%h ir=%h",
                        bus.ir_pc, bus.ir, exp_e[63:32], exp_e[31:0]);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Driver / check tasks
   // ---------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] a);
      exp_q.push_back({a, mem_word(a)});
   endtask

   // Waits (bounded) for the expected stream to be consumed.
   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d instructions missing, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   // One reset cycle, one idle cycle; returns at the start of the first
   // cycle in which a request is expected.
   task automatic do_reset(input bit check_state);
      bus.imem_gnt = 1'b0;
      bus.ir_ready = 1'b0;
      redirect     = 1'b0;
      rst_n        = 1'b0;
      step();
      rst_n = 1'b1;
      at_neg();
      if (check_state) begin
         chk1("rst_req",      bus.imem_req, 1'b0);
         chk1("rst_ir_valid", bus.ir_valid, 1'b0);
         chk ("rst_pc",       pc,           32'h0);
         chk ("rst_ir",       bus.ir,       32'h0);
         chk ("rst_ir_pc",    bus.ir_pc,    32'h0);
         chk1("rst_misalign", addr_misalign, 1'b0);
      end
      step();
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      rst_n        = 1'b0;
      redirect     = 1'b0;
      pc_source    = 3'd0;
      jalr         = 32'h0;
      branch       = 32'h0;
      jal          = 32'h0;
      mtvec        = 32'h0;
      mepc         = 32'h0;
      bus.imem_gnt = 1'b0;
      bus.ir_ready = 1'b0;
      step();

      // Test 1: reset state, then zero-wait streaming 0x0, 0x4, 0x8.
      do_reset(1'b1);
      mem_lat = 1; bus.ir_ready = 1'b1; bus.imem_gnt = 1'b1;
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      at_neg(); chk1("t1_req_c0", bus.imem_req, 1'b1); chk("t1_addr_c0", bus.imem_addr, 32'h0);
      step(); at_neg(); chk("t1_addr_c1", bus.imem_addr, 32'h4);
      step(); at_neg(); chk("t1_addr_c2", bus.imem_addr, 32'h8);
      chk1("t1_valid_c2", bus.ir_valid, 1'b1);
      step(); bus.imem_gnt = 1'b0; at_neg(); chk1("t1_valid_c3", bus.ir_valid, 1'b1);
      step(); at_neg(); chk1("t1_valid_c4", bus.ir_valid, 1'b1);
      step(); at_neg(); chk1("t1_valid_c5", bus.ir_valid, 1'b0);
      drain("t1");

      // Test 2: decode stalled from the start, then released.
      do_reset(1'b0);
      mem_lat = 1; bus.ir_ready = 1'b0; bus.imem_gnt = 1'b1;
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
      step(); step(); at_neg();
      chk1("t2_req_c2", bus.imem_req, 1'b0);
      chk1("t2_valid_c2", bus.ir_valid, 1'b1);
      chk ("t2_irpc_c2", bus.ir_pc, 32'h0);
      step(); at_neg();
      chk1("t2_req_c3", bus.imem_req, 1'b0);
      chk ("t2_irpc_c3", bus.ir_pc, 32'h0);
      chk ("t2_ir_c3", bus.ir, mem_word(32'h0));
      step(); bus.ir_ready = 1'b1; at_neg();
      chk1("t2_req_c4", bus.imem_req, 1'b1);
      chk ("t2_addr_c4", bus.imem_addr, 32'h8);
      step(); bus.imem_gnt = 1'b0;
      drain("t2");

      // Test 3: JAL redirect with 0x8 and 0xC in flight.
      do_reset(1'b0);
      mem_lat = 3; bus.ir_ready = 1'b1; bus.imem_gnt = 1'b1;
      push_exp(32'h0); push_exp(32'h4); push_exp(32'h100); push_exp(32'h104);
      for (int i = 0; i < 6; i++) step();
      redirect = 1'b1; pc_source = 3'd3; jal = 32'h100;
      jalr = 32'h300; branch = 32'h400; mtvec = 32'h500; mepc = 32'h600;
      at_neg();
      chk("t3_outstanding", 32'(pend_addr.size()), 32'd2);
      chk("t3_pend_head", pend_addr[0], 32'h8);
      step(); redirect = 1'b0; at_neg();
      chk1("t3_valid_after", bus.ir_valid, 1'b0);
      chk ("t3_pc_after", pc, 32'h100);
      chk1("t3_misalign", addr_misalign, 1'b0);
      step(); at_neg();
      chk1("t3_req_target", bus.imem_req, 1'b1);
      chk ("t3_addr_target", bus.imem_addr, 32'h100);
      step(); step(); bus.imem_gnt = 1'b0;
      drain("t3");

      // Test 4: BRANCH redirect in the cycle the response for 0x4 returns.
      do_reset(1'b0);
      mem_lat = 1; bus.ir_ready = 1'b1; bus.imem_gnt = 1'b1;
      push_exp(32'h0); push_exp(32'h40); push_exp(32'h44);
      step(); step();
      redirect = 1'b1; pc_source = 3'd2; branch = 32'h40;
      at_neg();
      chk1("t4_rvalid_redir", bus.imem_rvalid, 1'b1);
      chk1("t4_req_redir", bus.imem_req, 1'b0);
      step(); redirect = 1'b0; at_neg();
      chk1("t4_valid_after", bus.ir_valid, 1'b0);
      chk1("t4_req_after", bus.imem_req, 1'b1);
      chk ("t4_addr_after", bus.imem_addr, 32'h40);
      step(); step(); bus.imem_gnt = 1'b0;
      drain("t4");

      // Test 5: misaligned JALR, ignored code 6, back-to-back MTVEC/MEPC.
      redirect = 1'b1; pc_source = 3'd1; jalr = 32'h202;
      step(); redirect = 1'b0; at_neg();
      chk1("t5_misalign_hi", addr_misalign, 1'b1);
      chk ("t5_addr", bus.imem_addr, 32'h200);
      step(); at_neg();
      chk1("t5_misalign_lo", addr_misalign, 1'b0);
      step();
      redirect = 1'b1; pc_source = 3'd6;
      jalr = 32'h300; branch = 32'h320; jal = 32'h310; mtvec = 32'h330; mepc = 32'h334;
      step(); redirect = 1'b0; at_neg();
      chk ("t5_code6_pc", pc, 32'h200);
      chk1("t5_code6_misalign", addr_misalign, 1'b0);
      step();
      redirect = 1'b1; pc_source = 3'd4; mtvec = 32'h80;
      step(); pc_source = 3'd5; mepc = 32'hC4; at_neg();
      chk("t5_mtvec_pc", pc, 32'h80);
      step(); redirect = 1'b0; at_neg();
      chk ("t5_mepc_pc", pc, 32'hC4);
      chk1("t5_mepc_misalign", addr_misalign, 1'b0);
      step(); bus.imem_gnt = 1'b1; push_exp(32'hC4);
      at_neg(); chk1("t5_req", bus.imem_req, 1'b1);
      step(); bus.imem_gnt = 1'b0;
      drain("t5");

      // Test 6: reset with one word buffered and one still in flight.
      do_reset(1'b0);
      mem_lat = 4; bus.ir_ready = 1'b0; bus.imem_gnt = 1'b1;
      for (int i = 0; i < 5; i++) step();
      rst_n = 1'b0; bus.imem_gnt = 1'b0;
      at_neg();
      chk1("t6_pre_valid", bus.ir_valid, 1'b1);
      chk ("t6_pre_irpc", bus.ir_pc, 32'h0);
      chk ("t6_pre_outstanding", 32'(pend_addr.size()), 32'd1);
      step(); rst_n = 1'b1; mem_lat = 1; bus.ir_ready = 1'b1; bus.imem_gnt = 1'b1;
      at_neg();
      chk1("t6_rst_valid", bus.ir_valid, 1'b0);
      chk1("t6_rst_req", bus.imem_req, 1'b0);
      chk ("t6_rst_pc", pc, 32'h0);
      chk ("t6_rst_ir", bus.ir, 32'h0);
      push_exp(32'h0); push_exp(32'h4);
      step(); at_neg();
      chk1("t6_req", bus.imem_req, 1'b1);
      chk ("t6_addr", bus.imem_addr, 32'h0);
      step(); step(); bus.imem_gnt = 1'b0;
      drain("t6");

      step(); step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
